// File: rtl/pipe_stage_chain.sv
// ----------------------------------------------------------------------------
// pipe_stage_chain
//   A chain of DEPTH valid/ready register stages with bubble collapsing. Each
//   stage has a valid bit and a WIDTH-bit payload register. A stage loads
//   from its predecessor whenever it is empty or its successor is loading.
//   A flush empties every stage. Occupancy is the number of valid stages and
//   comes from a register.
//
// Parameters
//   WIDTH      payload width in bits
//   DEPTH      number of register stages (1..16)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears valid bits and payloads
//   in_valid   upstream offers in_data
//   in_ready   chain accepts in_data this cycle (combinational)
//   in_data    upstream payload
//   out_valid  out_data is valid this cycle (combinational, masked by flush)
//   out_ready  downstream consumes out_data this cycle
//   out_data   payload of the last stage (driven directly by a register)
//   flush      discard all held entries on this edge
//   occupancy  number of valid stages (registered)
// ----------------------------------------------------------------------------
module pipe_stage_chain #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH:0]   rdy;
   logic [DEPTH:0]   src_v;
   logic [WIDTH-1:0] src_data [DEPTH];
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;

   // Count of set bits in a stage-valid vector.
   function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] bits);
      logic [OCC_W-1:0] cnt;
      cnt = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         cnt = cnt + OCC_W'(bits[k]);
      end
      return cnt;
   endfunction

   // Readiness ripples backward from the output: a stage can load if it is
   // empty (bubble) or its content is moving on this cycle.
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = out_ready;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         rdy[k] = !v_q[k] || rdy[k+1];
      end
   end

   // Source of each stage: the upstream port for stage 0, else the previous stage.
   always_comb begin
      src_v       = {v_q, in_valid};
      src_data[0] = in_data;
      for (int k = 1; k < int'(DEPTH); k++) begin
         src_data[k] = data_q[k-1];
      end
   end

   // Next-state for valid bits and payloads; payload only loads real data so
   // empty slots never overwrite a stale value with garbage.
   always_comb begin
      v_d = v_q;
      for (int k = 0; k < int'(DEPTH); k++) begin
         data_d[k] = data_q[k];
      end
      if (flush) begin
         v_d = '0;
      end else begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            if (rdy[k]) begin
               v_d[k] = src_v[k];
               if (src_v[k]) begin
                  data_d[k] = src_data[k];
               end
            end
         end
      end
      occ_d = popcount(v_d);
   end

   // State registers; reset dominates flush and any transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q   <= '0;
         occ_q <= '0;
         for (int k = 0; k < int'(DEPTH); k++) begin
            data_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         occ_q <= occ_d;
         for (int k = 0; k < int'(DEPTH); k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign in_ready  = rdy[0] && !flush;
   assign out_valid = v_q[DEPTH-1] && !flush;
   assign out_data  = data_q[DEPTH-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_chain
//   Directed bench for pipe_stage_chain (DEPTH=3, WIDTH=9): reset state,
//   back-to-back streaming latency, full/stall and pass-through while full,
//   bubble collapse, flush, reset overriding flush, post-reset latency and a
//   patterned handshake run checked against a queue model.
// ----------------------------------------------------------------------------
module tb_pipe_stage_chain;

   localparam int unsigned WIDTH = 9;
   localparam int unsigned DEPTH = 3;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             flush;
   logic [1:0]       occupancy;

   int total;
   int bad;

   pipe_stage_chain #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] q[$];
      logic [WIDTH-1:0] seq;
      logic [31:0]      exp_out;
      int               n;

      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_occ",       32'(occupancy), 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);

      // Back-to-back stream, out_ready high: first output 3 cycles after accept
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 9'h001;
      #1;
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      chk("b2b_empty_ov", 32'(out_valid), 32'd0);
      tick();
      in_data = 9'h002;
      tick();
      in_data = 9'h003;
      tick();
      in_valid = 1'b0;
      #1;
      chk("b2b_ov0",  32'(out_valid), 32'd1);
      chk("b2b_od0",  32'(out_data),  32'h001);
      chk("b2b_occ0", 32'(occupancy), 32'd3);
      tick();
      chk("b2b_ov1",  32'(out_valid), 32'd1);
      chk("b2b_od1",  32'(out_data),  32'h002);
      chk("b2b_occ1", 32'(occupancy), 32'd2);
      tick();
      chk("b2b_ov2",  32'(out_valid), 32'd1);
      chk("b2b_od2",  32'(out_data),  32'h003);
      chk("b2b_occ2", 32'(occupancy), 32'd1);
      tick();
      chk("b2b_ov3",  32'(out_valid), 32'd0);
      chk("b2b_occ3", 32'(occupancy), 32'd0);

      // Fill while stalled, then pass-through while full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 9'h0A0;
      tick();
      in_data = 9'h0A1;
      tick();
      in_data = 9'h0A2;
      tick();
      in_data = 9'h0A3;
      #1;
      chk("full_occ",      32'(occupancy), 32'd3);
      chk("full_in_ready", 32'(in_ready),  32'd0);
      chk("full_od",       32'(out_data),  32'h0A0);
      chk("full_ov",       32'(out_valid), 32'd1);
      tick();
      chk("hold_occ", 32'(occupancy), 32'd3);
      chk("hold_od",  32'(out_data),  32'h0A0);
      out_ready = 1'b1;
      #1;
      chk("pass_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("pass_od1", 32'(out_data),  32'h0A1);
      chk("pass_occ", 32'(occupancy), 32'd3);
      tick();
      chk("pass_od2", 32'(out_data), 32'h0A2);
      tick();
      chk("pass_od3", 32'(out_data), 32'h0A3);
      chk("pass_ov3", 32'(out_valid), 32'd1);
      tick();
      chk("pass_empty", 32'(occupancy), 32'd0);

      // Bubble collapse behind a stalled head
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 9'h055;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("bub_occ1", 32'(occupancy), 32'd1);
      chk("bub_od",   32'(out_data),  32'h055);
      in_valid = 1'b1;
      in_data  = 9'h066;
      #1;
      chk("bub_in_ready0", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("bub_occ2",      32'(occupancy), 32'd2);
      chk("bub_in_ready1", 32'(in_ready),  32'd1);
      chk("bub_head",      32'(out_data),  32'h055);
      out_ready = 1'b1;
      tick();
      chk("bub_next_ov", 32'(out_valid), 32'd1);
      chk("bub_next_od", 32'(out_data),  32'h066);
      tick();
      chk("bub_drained", 32'(occupancy), 32'd0);

      // Flush with two entries held and a competing input
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 9'h011;
      tick();
      in_data = 9'h012;
      tick();
      in_valid = 1'b0;
      tick();
      chk("fl_pre_occ", 32'(occupancy), 32'd2);
      chk("fl_pre_ov",  32'(out_valid), 32'd1);
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 9'h1FF;
      out_ready = 1'b1;
      #1;
      chk("fl_in_ready",  32'(in_ready),  32'd0);
      chk("fl_out_valid", 32'(out_valid), 32'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("fl_post_occ", 32'(occupancy), 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("fl_no_out", 32'(out_valid), 32'd0);
         tick();
      end

      // Reset together with flush while full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 9'h021;
      tick();
      in_data = 9'h022;
      tick();
      in_data = 9'h023;
      tick();
      chk("rf_pre_occ", 32'(occupancy), 32'd3);
      reset     = 1'b1;
      flush     = 1'b1;
      in_data   = 9'h030;
      out_ready = 1'b1;
      tick();
      reset    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rf_ov",  32'(out_valid), 32'd0);
      chk("rf_od",  32'(out_data),  32'd0);
      chk("rf_occ", 32'(occupancy), 32'd0);

      // First post-reset entry emerges exactly DEPTH cycles after accept
      in_valid = 1'b1;
      in_data  = 9'h077;
      tick();
      in_valid = 1'b0;
      tick();
      chk("pr_early", 32'(out_valid), 32'd0);
      tick();
      chk("pr_ov", 32'(out_valid), 32'd1);
      chk("pr_od", 32'(out_data),  32'h077);
      tick();
      chk("pr_empty", 32'(occupancy), 32'd0);

      // Patterned handshake run against a queue model
      seq = 9'h100;
      for (int i = 0; i < 300; i++) begin
         in_valid  = ((i % 7) != 3) && ((i % 11) != 5);
         out_ready = ((i % 5) != 2) && (((i / 13) % 3) != 1);
         in_data   = seq;
         #1;
         n = q.size();
         chk("st_occ",      32'(occupancy), 32'(n));
         chk("st_in_ready", 32'(in_ready),  32'((n < int'(DEPTH)) || out_ready));
         if (out_valid && out_ready) begin
            exp_out = (n != 0) ? 32'(q.pop_front()) : 32'hDEAD;
            chk("st_out_data", 32'(out_data), exp_out);
         end
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            seq = seq + 9'd1;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < int'(DEPTH) + 2; i++) begin
         #1;
         if (out_valid) begin
            exp_out = (q.size() != 0) ? 32'(q.pop_front()) : 32'hDEAD;
            chk("drain_out_data", 32'(out_data), exp_out);
         end
         tick();
      end
      chk("drain_model_left", 32'(q.size()),  32'd0);
      chk("drain_occ",        32'(occupancy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 The module SHALL have parameter WIDTH, default 9, giving the payload width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 3, giving the number of register stages; legal range 1..16.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port in_valid  input  1  upstream offers in_data this cycle.
REQ-006 The module SHALL have port in_ready  output  1  chain accepts in_data this cycle.
REQ-007 The module SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 The module SHALL have port out_valid  output  1  out_data is valid this cycle.
REQ-009 The module SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 The module SHALL have port out_data  output  WIDTH  payload of the last stage.
REQ-011 The module SHALL have port flush  input  1  discard all held entries.
REQ-012 The module SHALL have port occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-013 Each stage k (0..DEPTH-1) SHALL hold a valid bit v[k] and a WIDTH-bit data register; stage 0 is fed by in_data, stage DEPTH-1 drives out_data/out_valid.
REQ-014 Per-stage readiness SHALL be combinational: rdy[DEPTH]=out_ready; rdy[k]=!v[k] || rdy[k+1].
REQ-015 in_ready SHALL equal rdy[0] && !flush; a transfer in occurs when in_valid && in_ready.
REQ-016 out_valid SHALL equal v[DEPTH-1] && !flush; a transfer out occurs when out_valid && out_ready.
REQ-017 When rdy[k] is high and flush is low, v[k] SHALL load v[k-1] (in_valid for k=0) and data[k] SHALL load data[k-1] (in_data for k=0) only if that source is valid; otherwise data[k] holds.
REQ-018 When rdy[k] is low, stage k SHALL hold both v[k] and data[k] (stall).
REQ-019 Bubbles SHALL collapse: an empty stage accepts from its predecessor even when later stages are stalled.
REQ-020 With out_ready held high and no flush, latency from transfer in to out_valid SHALL be exactly DEPTH cycles; throughput one entry per cycle.
REQ-021 Entries SHALL leave in the same order they entered; no entry is duplicated or dropped except by flush/reset.
REQ-022 When flush is high, every v[k] SHALL clear on that edge; no input is accepted and no output transfer is signalled in that cycle; data registers MAY hold stale values.
REQ-023 occupancy SHALL equal the population count of v[0..DEPTH-1], registered state only (no combinational dependence on handshake inputs).
REQ-024 When occupancy==DEPTH and out_ready is low, in_ready SHALL be low (full); when occupancy==DEPTH and out_ready is high, in_ready SHALL be high (pass-through while full).
REQ-025 When occupancy==0, out_valid SHALL be low regardless of out_ready (empty).
REQ-026 in_data SHALL NOT reach out_data combinationally for any DEPTH>=1.

Reset
REQ-027 On a rising clk edge with reset high, all v[k] SHALL clear to 0 and all data registers to 0; after that edge out_valid=0, out_data=0, occupancy=0.
REQ-028 During reset, in_ready SHALL follow REQ-015 from cleared state only after the reset edge; reset SHALL take priority over flush and over any transfer in the same cycle.
REQ-029 Reset asserted mid-operation SHALL discard all entries; the first post-reset transfer in SHALL appear after DEPTH cycles.

Verification
REQ-030 DEPTH=3, WIDTH=9, out_ready=1: drive 0x001,0x002,0x003 back-to-back -> out_data 0x001,0x002,0x003 on cycles 3,4,5 after first accept, out_valid continuous.
REQ-031 Fill with 0x0A0..0x0A2, out_ready=0 -> occupancy=3, in_ready=0, out_data=0x0A0 held; raise out_ready with in_valid=1 data 0x0A3 -> in_ready=1 same cycle, output order 0x0A0..0x0A3.
REQ-032 Bubble collapse: out_ready=0, single entry 0x055 reaches stage 2; then send 0x066 -> occupancy=2 after two cycles, 0x066 in stage 1, in_ready=1.
REQ-033 Flush with occupancy=2 and in_valid=1 data 0x1FF -> in_ready=0 and out_valid=0 that cycle; next cycle occupancy=0; 0x1FF never appears.
REQ-034 Reset asserted with occupancy=3 and flush=1 simultaneously -> next cycle out_valid=0, out_data=0, occupancy=0.
REQ-035 Random in_valid/out_ready (DEPTH=1 and DEPTH=5, 10k cycles) -> scoreboard shows in-order, lossless delivery and occupancy == accepted - delivered.
